// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_bus_pkg
// Brief  : Shared types and width defaults for the memory port arbiter.
// Rev    : 1.0
// ============================================================================
package mem_bus_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RD_WAIT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OWN_IF = 2'd0,
        OWN_DR = 2'd1,
        OWN_DW = 2'd2
    } owner_e;

endpackage
`default_nettype wire

// File: rtl/arb_prio_select.sv
`default_nettype none
// ============================================================================
// Module : arb_prio_select
// Brief  : Fixed-priority picker (dw > dr > if) with fetch starvation override.
// Rev    : 1.0
// ============================================================================
module arb_prio_select
    import mem_bus_pkg::*;
(
    input  logic   if_req_i,
    input  logic   dr_req_i,
    input  logic   dw_req_i,
    input  logic   lock_i,
    input  logic   starved_i,
    output logic   valid_o,
    output owner_e owner_o
);

    logic w_if_ok;

    // A held AMO lock hides fetch entirely, including its starvation override.
    assign w_if_ok = if_req_i & ~lock_i;

    always_comb begin
        valid_o = w_if_ok | dr_req_i | dw_req_i;
        owner_o = OWN_IF;
        if (w_if_ok && starved_i) begin
            owner_o = OWN_IF;
        end else if (dw_req_i) begin
            owner_o = OWN_DW;
        end else if (dr_req_i) begin
            owner_o = OWN_DR;
        end else begin
            owner_o = OWN_IF;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter
// Brief  : Shares one single-port memory bus between fetch, load and store.
// Rev    : 1.0
// ============================================================================
module mem_port_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = 8
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    input  logic                dr_req_i,
    input  logic [ADDR_W-1:0]   dr_addr_i,
    output logic                dr_gnt_o,
    output logic                dr_rvalid_o,
    input  logic                dw_req_i,
    input  logic [ADDR_W-1:0]   dw_addr_i,
    input  logic [DATA_W-1:0]   dw_wdata_i,
    input  logic [DATA_W/8-1:0] dw_wmask_i,
    output logic                dw_gnt_o,
    input  logic                d_lock_i,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wmask_o,
    input  logic                mem_accept_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = 8;

    state_e              state_q;
    owner_e              owner_q;
    logic [CNT_W-1:0]    starve_q, starve_d;
    logic                lock_q;
    logic                mem_req_q, mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q, rdata_q;
    logic [MASK_W-1:0]   mem_wmask_q;
    logic                if_gnt_q, dr_gnt_q, dw_gnt_q, if_rv_q, dr_rv_q;

    logic   w_if_req, w_dr_req, w_dw_req, w_starved, w_win_valid;
    owner_e w_win_owner;

    // A request still high during its own gnt cycle has already been served.
    assign w_if_req  = if_req_i & ~if_gnt_q;
    assign w_dr_req  = dr_req_i & ~dr_gnt_q;
    assign w_dw_req  = dw_req_i & ~dw_gnt_q;
    assign w_starved = (starve_q == CNT_W'(STARVE_MAX));

    arb_prio_select u_sel (
        .if_req_i  (w_if_req),
        .dr_req_i  (w_dr_req),
        .dw_req_i  (w_dw_req),
        .lock_i    (lock_q),
        .starved_i (w_starved),
        .valid_o   (w_win_valid),
        .owner_o   (w_win_owner)
    );

    always_comb begin
        starve_d = starve_q;
        if (state_q == REQ && mem_accept_i && owner_q == OWN_IF) begin
            starve_d = '0;
        end else if (state_q == IDLE && w_if_req && !w_starved &&
                     !(w_win_valid && w_win_owner == OWN_IF)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            starve_q    <= '0;
            lock_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            rdata_q     <= '0;
            if_gnt_q    <= 1'b0;
            dr_gnt_q    <= 1'b0;
            dw_gnt_q    <= 1'b0;
            if_rv_q     <= 1'b0;
            dr_rv_q     <= 1'b0;
        end else begin
            if_gnt_q <= 1'b0;
            dr_gnt_q <= 1'b0;
            dw_gnt_q <= 1'b0;
            if_rv_q  <= 1'b0;
            dr_rv_q  <= 1'b0;
            starve_q <= starve_d;
            case (state_q)
                IDLE: begin
                    if (!d_lock_i) lock_q <= 1'b0;
                    if (w_win_valid) begin
                        owner_q   <= w_win_owner;
                        mem_req_q <= 1'b1;
                        state_q   <= REQ;
                        case (w_win_owner)
                            OWN_IF: begin
                                mem_addr_q  <= if_addr_i;
                                mem_we_q    <= 1'b0;
                                mem_wdata_q <= '0;
                                mem_wmask_q <= '0;
                            end
                            OWN_DR: begin
                                mem_addr_q  <= dr_addr_i;
                                mem_we_q    <= 1'b0;
                                mem_wdata_q <= '0;
                                mem_wmask_q <= '0;
                            end
                            default: begin
                                mem_addr_q  <= dw_addr_i;
                                mem_we_q    <= 1'b1;
                                mem_wdata_q <= dw_wdata_i;
                                mem_wmask_q <= dw_wmask_i;
                            end
                        endcase
                    end
                end
                REQ: begin
                    if (mem_accept_i) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        case (owner_q)
                            OWN_IF: begin
                                if_gnt_q <= 1'b1;
                                state_q  <= RD_WAIT;
                            end
                            OWN_DR: begin
                                dr_gnt_q <= 1'b1;
                                if (d_lock_i) lock_q <= 1'b1;
                                state_q  <= RD_WAIT;
                            end
                            default: begin
                                dw_gnt_q <= 1'b1;
                                state_q  <= IDLE;
                            end
                        endcase
                    end
                end
                RD_WAIT: begin
                    if (mem_rvalid_i) begin
                        rdata_q <= mem_rdata_i;
                        if (owner_q == OWN_IF) if_rv_q <= 1'b1;
                        else                   dr_rv_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_gnt_o    = if_gnt_q;
    assign dr_gnt_o    = dr_gnt_q;
    assign dw_gnt_o    = dw_gnt_q;
    assign if_rvalid_o = if_rv_q;
    assign dr_rvalid_o = dr_rv_q;
    assign rdata_o     = rdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_wmask_o = mem_wmask_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_port_arbiter
// Brief  : Directed self-checking bench for mem_port_arbiter with a bus model.
// Rev    : 1.0
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        if_req_i, dr_req_i, dw_req_i, d_lock_i;
    logic [31:0] if_addr_i, dr_addr_i, dw_addr_i, dw_wdata_i;
    logic [3:0]  dw_wmask_i;
    logic        if_gnt_o, if_rvalid_o, dr_gnt_o, dr_rvalid_o, dw_gnt_o;
    logic [31:0] rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        mem_req_o, mem_we_o, mem_accept_i, mem_rvalid_i;
    logic [3:0]  mem_wmask_o;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(8)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o),
        .dr_req_i(dr_req_i), .dr_addr_i(dr_addr_i), .dr_gnt_o(dr_gnt_o), .dr_rvalid_o(dr_rvalid_o),
        .dw_req_i(dw_req_i), .dw_addr_i(dw_addr_i), .dw_wdata_i(dw_wdata_i), .dw_wmask_i(dw_wmask_i),
        .dw_gnt_o(dw_gnt_o), .d_lock_i(d_lock_i), .rdata_o(rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
        .mem_accept_i(mem_accept_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    logic [106:0] all_out;
    assign all_out = {if_gnt_o, if_rvalid_o, dr_gnt_o, dr_rvalid_o, dw_gnt_o, rdata_o,
                      mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o};

    // Bus model: accepts after accept_dly wait cycles, returns read data rvalid_dly cycles later.
    int          accept_dly = 0, rvalid_dly = 0, acc_cnt = 0, rv_cnt = 0;
    logic        rd_pend = 1'b0, bus_rv = 1'b0, stray_rv = 1'b0;
    logic [31:0] bus_rdata_val = 32'h0;
    assign mem_rvalid_i = bus_rv | stray_rv;
    assign mem_rdata_i  = bus_rdata_val;

    logic [31:0] log_addr[$];
    logic        log_we[$];
    int          gnt_order[$];
    int          n_if_gnt, n_dr_gnt, n_dw_gnt, n_if_rv, n_dr_rv;
    logic [31:0] last_rv_data;

    initial mem_accept_i = 1'b0;

    always @(negedge clk_i) begin
        if (!reset_i) begin
            mem_accept_i = 1'b0;
            bus_rv = 1'b0; rd_pend = 1'b0; acc_cnt = 0; rv_cnt = 0;
        end else begin
            if (if_gnt_o) begin n_if_gnt++; gnt_order.push_back(0); end
            if (dr_gnt_o) begin n_dr_gnt++; gnt_order.push_back(1); end
            if (dw_gnt_o) begin n_dw_gnt++; gnt_order.push_back(2); end
            if (if_rvalid_o) n_if_rv++;
            if (dr_rvalid_o) begin n_dr_rv++; last_rv_data = rdata_o; end
            bus_rv = 1'b0;
            if (rd_pend) begin
                if (rv_cnt >= rvalid_dly) begin bus_rv = 1'b1; rd_pend = 1'b0; rv_cnt = 0; end
                else rv_cnt++;
            end
            mem_accept_i = 1'b0;
            if (mem_req_o) begin
                if (acc_cnt >= accept_dly) begin
                    mem_accept_i = 1'b1; acc_cnt = 0;
                    log_addr.push_back(mem_addr_o); log_we.push_back(mem_we_o);
                    if (!mem_we_o) rd_pend = 1'b1;
                end else acc_cnt++;
            end else acc_cnt = 0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        reset_i = 1'b0;
        if_req_i = 1'b0; dr_req_i = 1'b0; dw_req_i = 1'b0; d_lock_i = 1'b0; stray_rv = 1'b0;
        repeat (2) @(negedge clk_i);
        n_if_gnt = 0; n_dr_gnt = 0; n_dw_gnt = 0; n_if_rv = 0; n_dr_rv = 0;
        log_addr.delete(); log_we.delete(); gnt_order.delete();
        last_rv_data = 32'h0;
        reset_i = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
        do_reset();
        repeat (3) @(negedge clk_i);
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL idle_outputs: got %h expected 0", all_out);
        end
    endtask

    task automatic test_priority();
        int first_dw_k;
        do_reset();
        accept_dly = 0; rvalid_dly = 0; bus_rdata_val = 32'hDEADBEEF;
        @(negedge clk_i);
        if_addr_i = 32'h10; dr_addr_i = 32'h20; dw_addr_i = 32'h30;
        dw_wdata_i = 32'h0; dw_wmask_i = 4'hF;
        if_req_i = 1'b1; dr_req_i = 1'b1; dw_req_i = 1'b1;
        first_dw_k = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_i);
            if (dw_gnt_o) begin dw_req_i = 1'b0; if (first_dw_k < 0) first_dw_k = k; end
            if (dr_gnt_o) dr_req_i = 1'b0;
            if (if_gnt_o) if_req_i = 1'b0;
            if (if_rvalid_o) break;
        end
        repeat (2) @(negedge clk_i);
        checks++;
        if (first_dw_k != 2) begin
            errors++; $display("FAIL prio_first_gnt_latency: got %0d expected 2", first_dw_k);
        end
        checks++;
        if (gnt_order.size() != 3 || gnt_order[0] != 2 || gnt_order[1] != 1 || gnt_order[2] != 0) begin
            errors++; $display("FAIL prio_gnt_order: got size %0d expected order dw,dr,if", gnt_order.size());
        end
        checks++;
        if (n_dr_rv != 1) begin
            errors++; $display("FAIL prio_dr_rvalid_count: got %0d expected 1", n_dr_rv);
        end
        checks++;
        if (last_rv_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL prio_dr_rdata: got %h expected deadbeef", last_rv_data);
        end
        checks++;
        if (n_if_rv != 1) begin
            errors++; $display("FAIL prio_if_rvalid_count: got %0d expected 1", n_if_rv);
        end
        checks++;
        if (log_addr.size() != 3 || log_addr[0] !== 32'h30 || log_addr[1] !== 32'h20 || log_addr[2] !== 32'h10) begin
            errors++; $display("FAIL prio_bus_addrs: got size %0d expected 30,20,10", log_addr.size());
        end
    endtask

    task automatic test_starvation();
        int data_cnt, fetches, first_cnt, second_cnt;
        do_reset();
        accept_dly = 0; rvalid_dly = 0; bus_rdata_val = 32'h12345678;
        @(negedge clk_i);
        if_addr_i = 32'h400; dr_addr_i = 32'h500; dw_addr_i = 32'h600;
        dw_wdata_i = 32'hFFFF0000; dw_wmask_i = 4'hF;
        if_req_i = 1'b1; dr_req_i = 1'b1; dw_req_i = 1'b1;
        data_cnt = 0; fetches = 0; first_cnt = -1; second_cnt = -1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk_i);
            if (dw_gnt_o || dr_gnt_o) data_cnt++;
            if (if_gnt_o) begin
                fetches++;
                if (fetches == 1) first_cnt = data_cnt;
                else second_cnt = data_cnt - first_cnt;
            end
            if (fetches == 2) break;
        end
        if_req_i = 1'b0; dr_req_i = 1'b0; dw_req_i = 1'b0;
        checks++;
        if (first_cnt != 8) begin
            errors++; $display("FAIL starve_first_fetch: got %0d data txns expected 8", first_cnt);
        end
        checks++;
        if (second_cnt != 8) begin
            errors++; $display("FAIL starve_counter_cleared: got %0d data txns expected 8", second_cnt);
        end
        repeat (6) @(negedge clk_i);
    endtask

    task automatic test_lock();
        int wait_dw;
        do_reset();
        accept_dly = 0; rvalid_dly = 0; bus_rdata_val = 32'h0A0B0C0D;
        @(negedge clk_i);
        d_lock_i = 1'b1; dr_addr_i = 32'h100; dr_req_i = 1'b1;
        if_addr_i = 32'h40; if_req_i = 1'b1;
        dw_addr_i = 32'h100; dw_wdata_i = 32'hA5A5A5A5; dw_wmask_i = 4'hF;
        wait_dw = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk_i);
            if (dr_gnt_o) dr_req_i = 1'b0;
            if (dr_rvalid_o) wait_dw = 2;
            else if (wait_dw > 0) begin
                wait_dw--;
                if (wait_dw == 0) dw_req_i = 1'b1;
            end
            if (dw_gnt_o) begin dw_req_i = 1'b0; d_lock_i = 1'b0; end
            if (if_gnt_o) if_req_i = 1'b0;
            if (if_rvalid_o) break;
        end
        repeat (2) @(negedge clk_i);
        checks++;
        if (log_addr.size() != 3) begin
            errors++; $display("FAIL lock_txn_count: got %0d expected 3", log_addr.size());
        end
        checks++;
        if (log_addr.size() < 3 || log_addr[0] !== 32'h100 || log_we[0] !== 1'b0 ||
            log_addr[1] !== 32'h100 || log_we[1] !== 1'b1 ||
            log_addr[2] !== 32'h40 || log_we[2] !== 1'b0) begin
            errors++; $display("FAIL lock_sequence: got first addr %h expected rd100,wr100,rd40",
                               (log_addr.size() > 0) ? log_addr[0] : 32'hX);
        end
        checks++;
        if (n_if_rv != 1) begin
            errors++; $display("FAIL lock_fetch_after_release: got %0d expected 1", n_if_rv);
        end
    endtask

    task automatic test_slow_bus();
        int req_cycles, unstable, gnt_k, rv_k;
        logic [31:0] held;
        do_reset();
        accept_dly = 3; rvalid_dly = 2; bus_rdata_val = 32'hCAFEF00D;
        @(negedge clk_i);
        dr_addr_i = 32'h55AA; dr_req_i = 1'b1;
        req_cycles = 0; unstable = 0; gnt_k = -1; rv_k = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk_i);
            if (mem_req_o) begin
                req_cycles++;
                if (mem_addr_o !== 32'h55AA || mem_we_o !== 1'b0) unstable++;
            end
            if (dr_gnt_o) begin dr_req_i = 1'b0; gnt_k = k; end
            if (dr_rvalid_o) begin rv_k = k; break; end
        end
        checks++;
        if (req_cycles != 4) begin
            errors++; $display("FAIL slow_req_cycles: got %0d expected 4", req_cycles);
        end
        checks++;
        if (unstable != 0) begin
            errors++; $display("FAIL slow_bus_stable: got %0d unstable cycles expected 0", unstable);
        end
        checks++;
        if (gnt_k != 5) begin
            errors++; $display("FAIL slow_gnt_cycle: got %0d expected 5", gnt_k);
        end
        checks++;
        if (rv_k != 8) begin
            errors++; $display("FAIL slow_rvalid_cycle: got %0d expected 8", rv_k);
        end
        checks++;
        if (rdata_o !== 32'hCAFEF00D) begin
            errors++; $display("FAIL slow_rdata: got %h expected cafef00d", rdata_o);
        end
        repeat (2) @(negedge clk_i);
        checks++;
        if (n_dr_gnt != 1 || n_dr_rv != 1) begin
            errors++; $display("FAIL slow_single_pulses: got gnt %0d rvalid %0d expected 1 1", n_dr_gnt, n_dr_rv);
        end
        held = rdata_o;
        bus_rdata_val = 32'h0BADBAD0;
        stray_rv = 1'b1;
        @(negedge clk_i);
        stray_rv = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++;
        if (n_dr_rv != 1 || n_if_rv != 0 || rdata_o !== 32'hCAFEF00D) begin
            errors++; $display("FAIL stray_rvalid: got dr_rv %0d if_rv %0d rdata %h expected 1 0 %h",
                               n_dr_rv, n_if_rv, rdata_o, held);
        end
    endtask

    task automatic test_write();
        int gnt_k;
        logic cap_we;
        logic [3:0] cap_mask;
        logic [31:0] cap_wdata, cap_addr;
        do_reset();
        accept_dly = 0; rvalid_dly = 0;
        @(negedge clk_i);
        dw_addr_i = 32'h2000; dw_wdata_i = 32'h11223344; dw_wmask_i = 4'b0101; dw_req_i = 1'b1;
        gnt_k = -1; cap_we = 1'b0; cap_mask = 4'h0; cap_wdata = 32'h0; cap_addr = 32'h0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk_i);
            if (mem_req_o) begin
                cap_we = mem_we_o; cap_mask = mem_wmask_o; cap_wdata = mem_wdata_o; cap_addr = mem_addr_o;
            end
            if (dw_gnt_o) begin dw_req_i = 1'b0; gnt_k = k; break; end
        end
        repeat (3) @(negedge clk_i);
        checks++;
        if (cap_we !== 1'b1) begin
            errors++; $display("FAIL write_we: got %b expected 1", cap_we);
        end
        checks++;
        if (cap_mask !== 4'b0101) begin
            errors++; $display("FAIL write_mask: got %b expected 0101", cap_mask);
        end
        checks++;
        if (cap_wdata !== 32'h11223344) begin
            errors++; $display("FAIL write_wdata: got %h expected 11223344", cap_wdata);
        end
        checks++;
        if (cap_addr !== 32'h2000) begin
            errors++; $display("FAIL write_addr: got %h expected 00002000", cap_addr);
        end
        checks++;
        if (gnt_k != 2) begin
            errors++; $display("FAIL write_gnt_cycle: got %0d expected 2", gnt_k);
        end
        checks++;
        if (n_dw_gnt != 1 || (n_if_rv + n_dr_rv) != 0) begin
            errors++; $display("FAIL write_pulses: got gnt %0d rvalids %0d expected 1 0", n_dw_gnt, n_if_rv + n_dr_rv);
        end
    endtask

    task automatic test_reset_mid_req();
        do_reset();
        accept_dly = 5; rvalid_dly = 0;
        @(negedge clk_i);
        dw_addr_i = 32'h3000; dw_wdata_i = 32'hBEEF0001; dw_wmask_i = 4'hF; dw_req_i = 1'b1;
        repeat (2) @(negedge clk_i);
        checks++;
        if (mem_req_o !== 1'b1) begin
            errors++; $display("FAIL midreset_in_req: got %b expected 1", mem_req_o);
        end
        #2 reset_i = 1'b0;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++; $display("FAIL midreset_async_clear: got %h expected 0", all_out);
        end
        @(negedge clk_i);
        reset_i = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk_i);
            if (dw_gnt_o) dw_req_i = 1'b0;
        end
        checks++;
        if (n_dw_gnt != 1 || log_addr.size() != 1) begin
            errors++; $display("FAIL midreset_regrant: got gnt %0d txns %0d expected 1 1", n_dw_gnt, log_addr.size());
        end
    endtask

    initial begin
        reset_i = 1'b0;
        if_req_i = 1'b0; dr_req_i = 1'b0; dw_req_i = 1'b0; d_lock_i = 1'b0;
        if_addr_i = '0; dr_addr_i = '0; dw_addr_i = '0; dw_wdata_i = '0; dw_wmask_i = '0;
        test_reset();
        test_priority();
        test_starvation();
        test_lock();
        test_slow_bus();
        test_write();
        test_reset_mid_req();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one external single-port memory bus between three pipeline requesters: instruction fetch (read), data read (load/AMO read), and data write (store/AMO write).
- Sits between the processor core's memory ports and the SoC memory bus.
- Issues one transaction at a time and converts the bus accept/rvalid handshake into per-requester grant and response strobes.
- Applies fixed priority with an anti-starvation override for fetch, and honours an atomic lock for AMO read-modify-write sequences.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; the write mask is DATA_W/8 bits.
- STARVE_MAX, 8, consecutive cycles fetch may be refused before it is forced to top priority; range 1..255.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-low reset.
- if_req_i  in  1  fetch read request; held until if_gnt_o.
- if_addr_i  in  ADDR_W  fetch address.
- if_gnt_o  out  1  fetch request accepted by the bus.
- if_rvalid_o  out  1  fetch read data valid.
- dr_req_i  in  1  data read request.
- dr_addr_i  in  ADDR_W  data read address.
- dr_gnt_o  out  1  data read accepted.
- dr_rvalid_o  out  1  data read data valid.
- dw_req_i  in  1  data write request.
- dw_addr_i  in  ADDR_W  data write address.
- dw_wdata_i  in  DATA_W  write data.
- dw_wmask_i  in  DATA_W/8  byte write mask.
- dw_gnt_o  out  1  write accepted; the write is complete.
- d_lock_i  in  1  AMO lock; reserves the bus for the data side.
- rdata_o  out  DATA_W  read data, valid with if_rvalid_o or dr_rvalid_o.
- mem_req_o  out  1  bus request.
- mem_we_o  out  1  bus write enable.
- mem_addr_o  out  ADDR_W  bus address.
- mem_wdata_o  out  DATA_W  bus write data.
- mem_wmask_o  out  DATA_W/8  bus byte mask.
- mem_accept_i  in  1  bus accepted the current request this cycle.
- mem_rvalid_i  in  1  bus read data valid.
- mem_rdata_i  in  DATA_W  bus read data.

Behaviour:
- Reset (reset_i low, asynchronous):
  - All outputs are 0; state is IDLE; starvation counter is 0; lock_owner is 0.
- States:
  - IDLE: no transaction on the bus.
  - REQ: request driven, waiting for mem_accept_i.
  - RD_WAIT: read accepted, waiting for mem_rvalid_i.
- Arbitration (evaluated combinationally in IDLE only):
  - Default priority: dw > dr > if.
  - Fetch is forced top priority when starve_cnt == STARVE_MAX.
  - Fetch is masked while lock_owner is 1.
  - The winner's address/data/mask are registered onto the mem_* outputs, mem_req_o is set, and the state moves to REQ on the next edge.
  - Bus outputs are registered and held stable throughout REQ.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) each cycle that if_req_i is high and fetch is not selected in IDLE.
  - Clears when fetch is granted.
- REQ exit on mem_accept_i:
  - Pulse the winner's gnt for exactly 1 cycle.
  - mem_req_o drops the same edge.
  - Write: return to IDLE.
  - Read: go to RD_WAIT.
- RD_WAIT on mem_rvalid_i:
  - Register mem_rdata_i into rdata_o.
  - Pulse the owner's rvalid for 1 cycle.
  - Return to IDLE.
  - mem_rvalid_i outside RD_WAIT is ignored.
- Latency: request to gnt is at least 2 cycles (arbitrate, then accept). With a zero-wait bus, a read delivers rvalid 1 cycle after accept at the earliest.
- Only one transaction is outstanding; a new arbitration begins only in IDLE.
- Lock:
  - lock_owner sets when dr is granted while d_lock_i is 1.
  - It clears in IDLE when d_lock_i is 0.
  - While set, only dr/dw may win, so an AMO read+write pair is never split by a fetch.
- Requesters dropping req before gnt: legal only in IDLE; once latched, the transaction completes regardless.
- Simultaneous requests with a saturated counter: fetch wins even over dw, unless the lock is set.
- rdata_o holds its last value between rvalid pulses.

Decomposition:
- Shared package mem_bus_pkg holds:
  - the state enum (IDLE, REQ, RD_WAIT);
  - the owner enum (OWN_IF, OWN_DR, OWN_DW);
  - ADDR_W/DATA_W defaults.
- One natural sub-module: arb_prio_select, a combinational priority picker with starvation override and lock mask. Everything else stays in the top.

Test Plan:
- Reset mid-REQ with a dw pending: assert reset_i low -> all outputs 0 immediately; after release, dw is re-arbitrated and dw_gnt_o pulses once.
- if+dr+dw all requesting, zero-wait bus, rdata 0xDEADBEEF -> dw_gnt, then dr_gnt + dr_rvalid with rdata_o=0xDEADBEEF, then if_gnt; order dw, dr, if.
- dw and dr held continuously with STARVE_MAX=8, if_req_i high -> if_gnt_o within 8 data transactions after starve_cnt reaches 8; counter returns to 0.
- d_lock_i=1 on dr at 0x100, then dw to 0x100, with if_req_i high throughout -> bus sequence is read 0x100, write 0x100, with no fetch in between; fetch follows once lock is released.
- Bus with mem_accept_i delayed 3 cycles and mem_rvalid_i delayed 2 -> mem_addr_o/mem_req_o are stable for all REQ cycles; single gnt and single rvalid pulses; stray mem_rvalid_i in IDLE produces no rvalid.
- Write with wmask 0b0101, wdata 0x11223344 at 0x2000 -> mem_we_o=1, mem_wmask_o=0b0101, mem_wdata_o=0x11223344, dw_gnt_o pulses on accept, no rvalid pulse.
